sap_out_display: RTL and testbench
==================================

Name: sap_out_display

Overview:
- Output-port stage directly downstream of the SAP-1 output register.
- Captures each 8-bit value the output register presents when its active-low load strobe fires during an OUT instruction.
- Converts the value to BCD with a sequential shift-add-3 (double-dabble) engine, one bit per clock.
- Drives a 4-digit multiplexed common-anode 7-segment display: sign digit plus hundreds, tens and units.

Parameters:
- SCAN_DIV, 1000: clocks per digit slot; legal range 2..65535.
- SIGNED_MODE, 0: 0 = unsigned 0..255; 1 = two's complement -128..127, magnitude shown with '-' on digit 3.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous active-high reset
- DATA_IN  input  8  output-register contents
- LO  input  1  active-low load strobe; same timing as the output-register load
- BCD  output  12  committed result {hundreds, tens, units}
- NEG  output  1  committed sign; 1 only when SIGNED_MODE=1 and the value is negative
- BUSY  output  1  high while a conversion is in flight
- DONE  output  1  one-cycle pulse when BCD/NEG update
- AN  output  4  digit enables, active-low one-hot; bit 0 = units, bit 3 = sign
- SEG  output  7  segments {g,f,e,d,c,b,a}, active-low

Behaviour:
- Reset (async, immediate):
  - state=IDLE, BCD=0, NEG=0, BUSY=0, DONE=0.
  - Scan counter=0, digit index=0, so AN=4'b1110 and SEG=7'b1000000 ('0').
  - Any conversion in progress is aborted.
- FSM states: IDLE, CONV, COMMIT.
- Capture:
  - LO sampled 0 at edge k, in any state: shift reg <= DATA_IN, or its magnitude (-DATA_IN, 8-bit) if SIGNED_MODE=1 and DATA_IN[7]=1.
  - Sign flag <= DATA_IN[7] & SIGNED_MODE; BCD accumulator <= 0; bit count <= 0; state <= CONV.
- Conversion:
  - Edges k+1..k+8, in CONV: each BCD nibble >= 5 gets +3, then {acc, shift} shifts left 1.
  - After the 8th shift, state <= COMMIT.
- Commit:
  - Edge k+9: BCD <= acc, NEG <= sign flag, DONE=1 for exactly the following cycle, state <= IDLE.
  - Latency: 9 clocks from LO sample to BCD update.
- Magnitude of 8'h80 is 128; the 8-bit negate wraps to 8'h80, which is treated as unsigned 128.
- BUSY = (state != IDLE).
- LO low while CONV or COMMIT restarts the capture with the new DATA_IN; the old result is never committed.
- LO held low for n edges recaptures on every edge; conversion starts after the first edge with LO=1.
- BCD/NEG hold their value between commits; the display always shows committed values, never intermediate ones.
- Scan:
  - Counter counts 0..SCAN_DIV-1; on wrap, digit index advances 0->1->2->3->0.
  - AN = ~(1 << index). SEG is a registered/combinational decode of the selected digit.
- Digit content:
  - Digit 0: units, always shown.
  - Digit 1: tens; blank (7'b1111111) if hundreds=0 and tens=0.
  - Digit 2: hundreds; blank if 0.
  - Digit 3: '-' (7'b0111111) if NEG, else blank.
- Digit codes, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Scan runs independently of conversion; captures never reset the scan.

Test Plan:
- Unsigned, LO low 1 clk with DATA_IN=8'h03 (program result 1+2+3-3) -> BUSY high 9 clks; DONE pulse at clk 10; BCD=12'h003; units SEG=0110000; tens and hundreds blank.
- Unsigned, DATA_IN=8'hFF -> BCD=12'h255, NEG=0. Then DATA_IN=8'h00 -> BCD=12'h000; only units shows '0'.
- SIGNED_MODE=1: 8'hFF -> BCD=12'h001, NEG=1, digit 3 SEG=0111111. 8'h80 -> BCD=12'h128, NEG=1. 8'h7F -> BCD=12'h127, NEG=0.
- Restart: load 8'hC8, then after 4 clks load 8'h2A -> exactly one DONE pulse, 9 clks after the second load; BCD=12'h042; 200 never appears.
- Reset mid-CONV after committing 8'h10 -> BUSY=0, BCD=0, AN=1110 immediately (async); no DONE follows.
- SCAN_DIV=4, committed value 123 -> AN cycles 1110,1101,1011,0111 every 4 clks; SEG shows 3,2,1 then blank.

Source files
------------

// File: rtl/sap_out_display.sv
// Output-port stage for the SAP-1: captures OUT values, converts them to BCD by
// sequential double-dabble and scans a 4-digit common-anode 7-segment display.
module sap_out_display #(
    parameter int SCAN_DIV    = 1000,
    parameter int SIGNED_MODE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  DATA_IN,
    input  logic        LO,
    output logic [11:0] BCD,
    output logic        NEG,
    output logic        BUSY,
    output logic        DONE,
    output logic [3:0]  AN,
    output logic [6:0]  SEG
);

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);
    localparam logic [6:0]  SEG_BLANK = 7'b1111111;
    localparam logic [6:0]  SEG_MINUS = 7'b0111111;

    state_t      state, state_nxt;
    logic [7:0]  shift_q;
    logic [11:0] acc_q;
    logic [11:0] acc_adj;
    logic [3:0]  bit_cnt;
    logic        sign_q;
    logic        cap_neg;
    logic [7:0]  cap_mag;
    logic [15:0] scan_cnt;
    logic [1:0]  digit_idx;

    // 8'h80 negates to itself, which is exactly the unsigned magnitude 128.
    assign cap_neg = (SIGNED_MODE != 0) && DATA_IN[7];
    assign cap_mag = cap_neg ? (~DATA_IN + 8'd1) : DATA_IN;

    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < 3; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5)
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = IDLE;
            CONV:    if (bit_cnt == 4'd7) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // A new load always wins, even over a pending commit.
        if (!LO)
            state_nxt = CONV;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= 8'd0;
            acc_q   <= 12'd0;
            bit_cnt <= 4'd0;
            sign_q  <= 1'b0;
            BCD     <= 12'd0;
            NEG     <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (!LO) begin
                shift_q <= cap_mag;
                sign_q  <= cap_neg;
                acc_q   <= 12'd0;
                bit_cnt <= 4'd0;
            end else begin
                case (state)
                    CONV: begin
                        acc_q   <= {acc_adj[10:0], shift_q[7]};
                        shift_q <= {shift_q[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                    COMMIT: begin
                        BCD  <= acc_q;
                        NEG  <= sign_q;
                        DONE <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign BUSY = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt  <= 16'd0;
            digit_idx <= 2'd0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt  <= 16'd0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 16'd1;
        end
    end

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    assign AN = ~(4'b0001 << digit_idx);

    // Leading zeros are blanked; units always shows a digit.
    always_comb begin
        SEG = SEG_BLANK;
        case (digit_idx)
            2'd0: SEG = seg_of(BCD[3:0]);
            2'd1: if (BCD[11:8] != 4'd0 || BCD[7:4] != 4'd0) SEG = seg_of(BCD[7:4]);
            2'd2: if (BCD[11:8] != 4'd0) SEG = seg_of(BCD[11:8]);
            2'd3: if (NEG) SEG = SEG_MINUS;
            default: SEG = SEG_BLANK;
        endcase
    end

endmodule

// File: tb/tb_sap_out_display.sv
// Bench for sap_out_display: an unsigned and a signed instance share stimulus and
// are compared against a decimal-arithmetic model of the conversion and the scan.
module tb_sap_out_display;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        LO = 1'b1;
    logic [7:0]  DATA_IN = 8'd0;

    logic [11:0] bcd_u, bcd_s;
    logic        neg_u, neg_s, busy_u, busy_s, done_u, done_s;
    logic [3:0]  an_u, an_s;
    logic [6:0]  seg_u, seg_s;

    int cyc = 0;
    int pass_cnt = 0;
    int check_cnt = 0;

    sap_out_display #(.SCAN_DIV(SD), .SIGNED_MODE(0)) dut_u (
        .clk(clk), .rst(rst), .DATA_IN(DATA_IN), .LO(LO),
        .BCD(bcd_u), .NEG(neg_u), .BUSY(busy_u), .DONE(done_u), .AN(an_u), .SEG(seg_u));

    sap_out_display #(.SCAN_DIV(SD), .SIGNED_MODE(1)) dut_s (
        .clk(clk), .rst(rst), .DATA_IN(DATA_IN), .LO(LO),
        .BCD(bcd_s), .NEG(neg_s), .BUSY(busy_s), .DONE(done_s), .AN(an_s), .SEG(seg_s));

    always #5 clk = ~clk;

    // Edges since reset release; the scan position follows from this alone.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic int ref_val(input logic [7:0] d, input bit sgn);
        int v;
        v = int'(d);
        if (sgn && d[7]) v = 256 - v;
        return v;
    endfunction

    function automatic logic [11:0] ref_bcd(input logic [7:0] d, input bit sgn);
        int v;
        v = ref_val(d, sgn);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] digit_code(input int n);
        case (n)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] ref_seg(input int v, input bit neg, input int idx);
        case (idx)
            0: return digit_code(v % 10);
            1: return (v >= 10) ? digit_code((v / 10) % 10) : 7'b1111111;
            2: return (v >= 100) ? digit_code(v / 100) : 7'b1111111;
            default: return neg ? 7'b0111111 : 7'b1111111;
        endcase
    endfunction

    function automatic logic [3:0] ref_an(input int idx);
        case (idx)
            0: return 4'b1110;
            1: return 4'b1101;
            2: return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1; LO = 1'b1; DATA_IN = 8'd0;
        #12;
        check_cnt++; if ({busy_u, done_u, neg_u, bcd_u} !== 15'd0) $display("FAIL reset_u got=%h exp=0", {busy_u, done_u, neg_u, bcd_u}); else pass_cnt++;
        check_cnt++; if ({busy_s, done_s, neg_s, bcd_s} !== 15'd0) $display("FAIL reset_s got=%h exp=0", {busy_s, done_s, neg_s, bcd_s}); else pass_cnt++;
        check_cnt++; if ({an_u, seg_u} !== {4'b1110, 7'b1000000}) $display("FAIL reset_disp got=%b_%b exp=1110_1000000", an_u, seg_u); else pass_cnt++;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_latency();
        DATA_IN = 8'h03; LO = 1'b0;
        @(negedge clk); LO = 1'b1;
        for (int i = 0; i < 9; i++) begin
            check_cnt++; if ({busy_u, done_u} !== 2'b10) $display("FAIL lat_busy i=%0d got=%b exp=10", i, {busy_u, done_u}); else pass_cnt++;
            @(negedge clk);
        end
        check_cnt++; if ({busy_u, done_u, bcd_u} !== {2'b01, 12'h003}) $display("FAIL lat_done got=%b_%h exp=01_003", {busy_u, done_u}, bcd_u); else pass_cnt++;
        @(negedge clk);
        check_cnt++; if (done_u !== 1'b0) $display("FAIL lat_pulse got=%b exp=0", done_u); else pass_cnt++;
    endtask

    task automatic test_conversions();
        logic [7:0] vals [$];
        logic [7:0] d;
        int idx;
        vals = '{8'h03, 8'hFF, 8'h00, 8'h80, 8'h7F, 8'h7B, 8'hC8, 8'h64};
        for (int i = 0; i < 10; i++) vals.push_back(8'($urandom_range(0, 255)));
        foreach (vals[n]) begin
            d = vals[n];
            DATA_IN = d; LO = 1'b0;
            @(negedge clk); LO = 1'b1; DATA_IN = 8'($urandom);
            repeat (10) @(negedge clk);
            check_cnt++; if ({neg_u, bcd_u} !== {1'b0, ref_bcd(d, 0)}) $display("FAIL conv_u d=%h got=%b_%h exp=0_%h", d, neg_u, bcd_u, ref_bcd(d, 0)); else pass_cnt++;
            check_cnt++; if ({neg_s, bcd_s} !== {d[7], ref_bcd(d, 1)}) $display("FAIL conv_s d=%h got=%b_%h exp=%b_%h", d, neg_s, bcd_s, d[7], ref_bcd(d, 1)); else pass_cnt++;
            for (int k = 0; k < 4 * SD; k++) begin
                idx = (cyc / SD) % 4;
                check_cnt++; if ({an_u, an_s} !== {ref_an(idx), ref_an(idx)}) $display("FAIL scan_an d=%h got=%b_%b exp=%b", d, an_u, an_s, ref_an(idx)); else pass_cnt++;
                check_cnt++; if (seg_u !== ref_seg(ref_val(d, 0), 0, idx)) $display("FAIL seg_u d=%h idx=%0d got=%b exp=%b", d, idx, seg_u, ref_seg(ref_val(d, 0), 0, idx)); else pass_cnt++;
                check_cnt++; if (seg_s !== ref_seg(ref_val(d, 1), d[7], idx)) $display("FAIL seg_s d=%h idx=%0d got=%b exp=%b", d, idx, seg_s, ref_seg(ref_val(d, 1), d[7], idx)); else pass_cnt++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_restart();
        int dones, done_at;
        bit saw200;
        DATA_IN = 8'h00; LO = 1'b0;
        @(negedge clk); LO = 1'b1;
        repeat (10) @(negedge clk);
        DATA_IN = 8'hC8; LO = 1'b0;
        @(negedge clk); LO = 1'b1;
        dones = 0; done_at = -1; saw200 = 0;
        for (int i = 0; i < 3; i++) begin
            if (done_u) dones++;
            @(negedge clk);
        end
        DATA_IN = 8'h2A; LO = 1'b0;
        @(negedge clk); LO = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (done_u) begin dones++; done_at = i; end
            if (bcd_u == 12'h200) saw200 = 1;
            @(negedge clk);
        end
        check_cnt++; if (dones !== 1) $display("FAIL restart_cnt got=%0d exp=1", dones); else pass_cnt++;
        check_cnt++; if (done_at !== 9) $display("FAIL restart_lat got=%0d exp=9", done_at); else pass_cnt++;
        check_cnt++; if (saw200 !== 1'b0) $display("FAIL restart_200 got=%b exp=0", saw200); else pass_cnt++;
        check_cnt++; if (bcd_u !== 12'h042) $display("FAIL restart_bcd got=%h exp=042", bcd_u); else pass_cnt++;
    endtask

    task automatic test_hold();
        int done_at;
        bit busy_ok;
        done_at = -1; busy_ok = 1;
        LO = 1'b0;
        DATA_IN = 8'h11; @(negedge clk);
        DATA_IN = 8'h22; @(negedge clk);
        DATA_IN = 8'h33; @(negedge clk);
        LO = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (done_u && done_at < 0) done_at = i;
            if (i < 9 && !busy_u) busy_ok = 0;
            @(negedge clk);
        end
        check_cnt++; if (done_at !== 9) $display("FAIL hold_lat got=%0d exp=9", done_at); else pass_cnt++;
        check_cnt++; if (busy_ok !== 1'b1) $display("FAIL hold_busy got=%b exp=1", busy_ok); else pass_cnt++;
        check_cnt++; if (bcd_u !== ref_bcd(8'h33, 0)) $display("FAIL hold_bcd got=%h exp=%h", bcd_u, ref_bcd(8'h33, 0)); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        DATA_IN = 8'h10; LO = 1'b0;
        @(negedge clk); LO = 1'b1;
        repeat (10) @(negedge clk);
        check_cnt++; if (bcd_u !== 12'h016) $display("FAIL rmid_pre got=%h exp=016", bcd_u); else pass_cnt++;
        DATA_IN = 8'h55; LO = 1'b0;
        @(negedge clk); LO = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_cnt++; if ({busy_u, bcd_u, an_u} !== {1'b0, 12'h000, 4'b1110}) $display("FAIL rmid_async got=%b_%h_%b exp=0_000_1110", busy_u, bcd_u, an_u); else pass_cnt++;
        check_cnt++; if ({busy_s, bcd_s, seg_s} !== {1'b0, 12'h000, 7'b1000000}) $display("FAIL rmid_async_s got=%b_%h_%b exp=0_000_1000000", busy_s, bcd_s, seg_s); else pass_cnt++;
        @(negedge clk); rst = 1'b0;
        saw_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done_u || done_s) saw_done = 1;
            @(negedge clk);
        end
        check_cnt++; if (saw_done !== 1'b0) $display("FAIL rmid_nodone got=%b exp=0", saw_done); else pass_cnt++;
        check_cnt++; if (bcd_u !== 12'h000) $display("FAIL rmid_hold got=%h exp=000", bcd_u); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_conversions();
        test_restart();
        test_hold();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
